// File: rtl/operand_fetch_queue_if.sv
// Bus bundle for operand_fetch_queue: instruction input side and decoded-operand output side.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; valid never waits on ready.
interface operand_fetch_queue_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] pc;
  logic              isret;
  logic              isst;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        opcode;
  logic              imm_flag;
  logic [3:0]        rd;
  logic [DATA_W-1:0] immx;
  logic [DATA_W-1:0] branch_target;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  modport master (
    output in_valid, instruction, pc, isret, isst, out_ready,
    input  in_ready, out_valid, opcode, imm_flag, rd, immx, branch_target, op1, op2
  );

  modport slave (
    input  in_valid, instruction, pc, isret, isst, out_ready,
    output in_ready, out_valid, opcode, imm_flag, rd, immx, branch_target, op1, op2
  );
endinterface

// File: rtl/operand_fetch_queue.sv
// Operand-fetch stage: decode, register-file read with writeback bypass, and an output queue
// whose queued operands are patched by later writebacks.
module operand_fetch_queue #(
  parameter int DATA_W    = 32,
  parameter int OUT_DEPTH = 2,
  parameter int RET_REG   = 15,
  localparam int PW       = $clog2(OUT_DEPTH),
  localparam int CW       = $clog2(OUT_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_fetch_queue_if.slave bus,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [CW-1:0]     count
);

  localparam logic [3:0] RET_A = 4'(RET_REG);

  logic [DATA_W-1:0] rf [16];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [4:0]        opc_q  [OUT_DEPTH];
  logic              i_q    [OUT_DEPTH];
  logic [3:0]        rd_q   [OUT_DEPTH];
  logic [3:0]        a1_q   [OUT_DEPTH];
  logic [3:0]        a2_q   [OUT_DEPTH];
  logic [DATA_W-1:0] immx_q [OUT_DEPTH];
  logic [DATA_W-1:0] bt_q   [OUT_DEPTH];
  logic [DATA_W-1:0] op1_q  [OUT_DEPTH];
  logic [DATA_W-1:0] op2_q  [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] vld;

  logic [31:0]       ins;
  logic [3:0]        a1;
  logic [3:0]        a2;
  logic [DATA_W-1:0] op1_in;
  logic [DATA_W-1:0] op2_in;
  logic [DATA_W-1:0] immx_in;
  logic [DATA_W-1:0] bt_in;
  logic              full;
  logic              accept;
  logic              pop;

  assign ins    = bus.instruction;
  assign a1     = bus.isret ? RET_A : ins[21:18];
  assign a2     = bus.isst  ? ins[25:22] : ins[17:14];
  assign op1_in = (wb_en && (wb_addr == a1)) ? wb_data : rf[a1];
  assign op2_in = (wb_en && (wb_addr == a2)) ? wb_data : rf[a2];
  assign bt_in  = bus.pc + ({{(DATA_W-27){ins[26]}}, ins[26:0]} << 2);

  always_comb begin
    immx_in = '0;
    if (ins[26]) begin
      case (ins[17:16])
        2'b00:   immx_in = {{(DATA_W-16){ins[15]}}, ins[15:0]};
        2'b01:   immx_in = DATA_W'(ins[15:0]);
        2'b10:   immx_in = DATA_W'({ins[15:0], 16'h0000});
        default: immx_in = '0;
      endcase
    end
  end

  // Ready depends only on registered occupancy, so a same-cycle pop never reopens a full queue.
  assign full          = (count == CW'(OUT_DEPTH));
  assign bus.in_ready  = !full;
  assign bus.out_valid = (count != '0);
  assign accept        = bus.in_valid && !full && !flush;
  assign pop           = bus.out_valid && bus.out_ready && !flush;

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < OUT_DEPTH; i++) begin
      vld[i] = ({1'b0, PW'(i) - rd_ptr} < count);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        opc_q[i]  <= '0;
        i_q[i]    <= 1'b0;
        rd_q[i]   <= '0;
        a1_q[i]   <= '0;
        a2_q[i]   <= '0;
        immx_q[i] <= '0;
        bt_q[i]   <= '0;
        op1_q[i]  <= '0;
        op2_q[i]  <= '0;
      end
    end else begin
      // Late writebacks refresh operands of entries already waiting, including the head.
      if (wb_en) begin
        for (int i = 0; i < OUT_DEPTH; i++) begin
          if (vld[i] && (a1_q[i] == wb_addr)) op1_q[i] <= wb_data;
          if (vld[i] && (a2_q[i] == wb_addr)) op2_q[i] <= wb_data;
        end
      end
      if (accept) begin
        opc_q[wr_ptr]  <= ins[31:27];
        i_q[wr_ptr]    <= ins[26];
        rd_q[wr_ptr]   <= ins[25:22];
        a1_q[wr_ptr]   <= a1;
        a2_q[wr_ptr]   <= a2;
        immx_q[wr_ptr] <= immx_in;
        bt_q[wr_ptr]   <= bt_in;
        op1_q[wr_ptr]  <= op1_in;
        op2_q[wr_ptr]  <= op2_in;
      end
    end
  end

  assign bus.opcode        = opc_q[rd_ptr];
  assign bus.imm_flag      = i_q[rd_ptr];
  assign bus.rd            = rd_q[rd_ptr];
  assign bus.immx          = immx_q[rd_ptr];
  assign bus.branch_target = bt_q[rd_ptr];
  assign bus.op1           = op1_q[rd_ptr];
  assign bus.op2           = op2_q[rd_ptr];

endmodule
